pipe_int_mul_ctrl: RTL and testbench

Control unit for the 4-stage pipelined 32x32 integer multiplier datapath (stages MF, C0, C1, C2, C3, MP).
- Accepts operand pairs through a val/rdy input handshake.
- Drives the per-stage pipeline-register enables, and issues start pulses to each 8x32 iterative multiplier stage.
- Collects each stage's commit pulse, and presents the finished 64-bit product through a val/rdy output handshake.
- Handles stalls and backpressure so that no operation is dropped or duplicated.

---
 rtl/pipe_int_mul_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_int_mul_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_int_mul_ctrl.sv
// Purpose: control unit for the 4-stage pipelined 32x32 multiplier (MF, C0..C3, MP); build with PIPE_MUL_PERF_EN for perf counters.
// Latency: accept to out_val = 1 + sum over stages of (L_n + 1) cycles, where L_n is a stage's start-to-commit time.
// Backpressure: out_rdy low holds MP and stalls upstream stages in place; in_rdy drops once C0 cannot refill.
module pipe_int_mul_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             reg_en_MF,
  output logic             reg_en_C0,
  output logic             reg_en_C1,
  output logic             reg_en_C2,
  output logic             reg_en_C3,
  output logic             val_op_C0,
  output logic             val_op_C1,
  output logic             val_op_C2,
  output logic             val_op_C3,
  input  logic             commit_C0,
  input  logic             commit_C1,
  input  logic             commit_C2,
  input  logic             commit_C3,
  output logic             busy
`ifdef PIPE_MUL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_ops,
  output logic [CNT_W-1:0] perf_stall
`endif
);

  localparam int NSTG = 4;

  // Per-stage flags: v = holds an op, s = start pulse issued, d = commit received.
  logic [NSTG-1:0] v_q;
  logic [NSTG-1:0] s_q;
  logic [NSTG-1:0] d_q;
  logic            v_mp_q;

  logic [NSTG-1:0] commit;
  logic [NSTG-1:0] go;
  logic [NSTG-1:0] load;
  logic [NSTG-1:0] val_op;
  logic            go_mp;
  logic            rdy_raw;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  assign commit = {commit_C3, commit_C2, commit_C1, commit_C0};

  // Advance chain: a stage moves on once its result is in and the slot
  // downstream is either empty or emptying in this same cycle.
  always_comb begin
    go_mp = v_mp_q & out_rdy;
    go    = '0;
    go[NSTG-1] = v_q[NSTG-1] & d_q[NSTG-1] & (~v_mp_q | go_mp);
    for (int n = NSTG - 2; n >= 0; n--) begin
      go[n] = v_q[n] & d_q[n] & (~v_q[n+1] | go[n+1]);
    end
  end

  // in_rdy looks only at stage state and the downstream chain, never at in_val.
  assign rdy_raw = ~v_q[0] | go[0];

  // Stage n is loaded by the accept (n=0) or by the stage above advancing.
  assign load   = {go[NSTG-2:0], in_val & rdy_raw};

  // A stage starts its multiplier in the first cycle it holds an operation.
  assign val_op = v_q & ~s_q;

  // Every output is held low while reset is asserted.
  assign in_rdy    = ~reset & rdy_raw;
  assign out_val   = ~reset & v_mp_q;
  assign reg_en_MF = ~reset & load[0];
  assign reg_en_C0 = ~reset & go[0];
  assign reg_en_C1 = ~reset & go[1];
  assign reg_en_C2 = ~reset & go[2];
  assign reg_en_C3 = ~reset & go[3];
  assign val_op_C0 = ~reset & val_op[0];
  assign val_op_C1 = ~reset & val_op[1];
  assign val_op_C2 = ~reset & val_op[2];
  assign val_op_C3 = ~reset & val_op[3];
  assign busy      = ~reset & ((|v_q) | v_mp_q);

  // Stage flags: a load wins over an advance so a draining stage refills with
  // no bubble; d sticks until the stage advances so a stalled result is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      s_q <= '0;
      d_q <= '0;
    end else begin
      for (int n = 0; n < NSTG; n++) begin
        if (load[n]) begin
          v_q[n] <= 1'b1;
          s_q[n] <= 1'b0;
          d_q[n] <= 1'b0;
        end else if (go[n]) begin
          v_q[n] <= 1'b0;
          s_q[n] <= 1'b0;
          d_q[n] <= 1'b0;
        end else begin
          if (val_op[n]) begin
            s_q[n] <= 1'b1;
          end
          // A commit counts only after the start pulse has gone out, which
          // also drops stray pulses from ops discarded by a reset.
          if (commit[n] & v_q[n] & s_q[n]) begin
            d_q[n] <= 1'b1;
          end
        end
      end
    end
  end

  // Output slot: refilled from C3 takes priority over draining to the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_mp_q <= 1'b0;
    end else if (go[NSTG-1]) begin
      v_mp_q <= 1'b1;
    end else if (go_mp) begin
      v_mp_q <= 1'b0;
    end
  end

`ifdef PIPE_MUL_PERF_EN
  logic [CNT_W-1:0] ops_q;
  logic [CNT_W-1:0] stall_q;

  // Completed-op and input-stall counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (go_mp) begin
        ops_q <= ops_q + 1'b1;
      end
      if (in_val & ~rdy_raw) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign perf_ops   = reset ? '0 : ops_q;
  assign perf_stall = reset ? '0 : stall_q;
`endif

`ifndef SYNTHESIS
  // Each op sees a single start pulse: the cycle after a pulse, s is set and
  // the stage cannot have been refilled because d is still clear.
  for (genvar n = 0; n < NSTG; n++) begin : g_chk
    a_one_pulse: assert property (@(posedge clk) disable iff (reset)
      val_op[n] |=> !val_op[n]);
  end

  a_d_after_s: assert property (@(posedge clk) disable iff (reset)
    (d_q & ~s_q) == '0);

  a_flags_need_v: assert property (@(posedge clk) disable iff (reset)
    ((s_q | d_q) & ~v_q) == '0);
`endif

endmodule

// File: tb/tb_pipe_int_mul_ctrl.sv
// Bench for pipe_int_mul_ctrl: models the per-stage multipliers and the datapath registers.
// Stimulus and checks run on the falling edge; the scoreboard follows accepted operand pairs.
// out_rdy is driven by the tests to exercise stalls and backpressure.
module tb_pipe_int_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic        out_val;
  logic        out_rdy = 1'b1;
  logic        reg_en_MF, reg_en_C0, reg_en_C1, reg_en_C2, reg_en_C3;
  logic        val_op_C0, val_op_C1, val_op_C2, val_op_C3;
  logic        commit_C0, commit_C1, commit_C2, commit_C3;
  logic        busy;
`ifdef PIPE_MUL_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;
`endif

  logic [3:0]  commit_v = 4'b0;
  logic [31:0] int_a = 32'd0;
  logic [31:0] int_b = 32'd0;

  assign commit_C0 = commit_v[0];
  assign commit_C1 = commit_v[1];
  assign commit_C2 = commit_v[2];
  assign commit_C3 = commit_v[3];

  wire [3:0] val_op_v = {val_op_C3, val_op_C2, val_op_C1, val_op_C0};
  wire [4:0] reg_en_v = {reg_en_C3, reg_en_C2, reg_en_C1, reg_en_C0, reg_en_MF};

  pipe_int_mul_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .reg_en_MF (reg_en_MF),
    .reg_en_C0 (reg_en_C0),
    .reg_en_C1 (reg_en_C1),
    .reg_en_C2 (reg_en_C2),
    .reg_en_C3 (reg_en_C3),
    .val_op_C0 (val_op_C0),
    .val_op_C1 (val_op_C1),
    .val_op_C2 (val_op_C2),
    .val_op_C3 (val_op_C3),
    .commit_C0 (commit_C0),
    .commit_C1 (commit_C1),
    .commit_C2 (commit_C2),
    .commit_C3 (commit_C3),
    .busy      (busy)
`ifdef PIPE_MUL_PERF_EN
    ,
    .perf_ops  (perf_ops),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state.
  int          lat [4] = '{9, 9, 9, 9};
  int          cnt [4] = '{0, 0, 0, 0};
  int          vop_cnt [4] = '{0, 0, 0, 0};
  int          cyc = 0;
  int          acc_cnt = 0;
  int          out_cnt = 0;
  int          outval_cycles = 0;
  int          last_acc_cyc = 0;
  int          last_out_cyc = 0;
  int          prev_out_cyc = 0;
  int          stall_cnt = 0;
  logic [63:0] exp_q [$];
  logic [63:0] cur_exp = 64'd0;
  logic [63:0] dp_c [4];
  logic [63:0] dp_mp = 64'd0;

  // Per-cycle model: stage multipliers (commit in the L-th cycle counting the
  // start cycle as the first), datapath registers and the scoreboard.
  initial begin
    logic [63:0] got;
    logic [63:0] want;
    for (int n = 0; n < 4; n++) dp_c[n] = 64'd0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int n = 0; n < 4; n++) begin
        commit_v[n] = (cnt[n] == 1);
        if (cnt[n] > 0) cnt[n]--;
      end
      #1;
      for (int n = 0; n < 4; n++) begin
        if (val_op_v[n]) begin
          cnt[n] = lat[n] - 1;
          vop_cnt[n]++;
        end
      end
      if (!reset && in_val && !in_rdy) stall_cnt++;
      if (out_val) begin
        outval_cycles++;
        if (out_rdy) begin
          got = {32'd0, dp_mp[63:32]} * {32'd0, dp_mp[31:0]};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got product %h, expected nothing", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL sb_product: got %h, expected %h", got, want);
            end
          end
          out_cnt++;
          prev_out_cyc = last_out_cyc;
          last_out_cyc = cyc;
        end
      end
      if (reg_en_MF) begin
        exp_q.push_back(cur_exp);
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (reg_en_C3) dp_mp = dp_c[3];
      if (reg_en_C2) dp_c[3] = dp_c[2];
      if (reg_en_C1) dp_c[2] = dp_c[1];
      if (reg_en_C0) dp_c[1] = dp_c[0];
      if (reg_en_MF) dp_c[0] = {int_a, int_b};
    end
  end

  // Present an operand pair and hold it until accepted or the budget runs out.
  // On success the caller is inside the accept cycle with in_val still high.
  task automatic offer(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e, input int budget, output bit ok);
    @(negedge clk);
    in_val  = 1'b1;
    int_a   = a;
    int_b   = b;
    cur_exp = e;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (in_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_val = 1'b1; out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy: got %b, expected 0", in_rdy); end
    checks++; if (reg_en_v !== 5'b0) begin errors++; $display("FAIL rst_reg_en: got %b, expected 00000", reg_en_v); end
    checks++; if ({out_val, busy} !== 2'b00) begin errors++; $display("FAIL rst_out_busy: got %b, expected 00", {out_val, busy}); end
    @(negedge clk);
    reset = 1'b0; in_val = 1'b0;
    #2;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL idle_in_rdy: got %b, expected 1", in_rdy); end
    checks++; if ({out_val, busy} !== 2'b00) begin errors++; $display("FAIL idle_out_busy: got %b, expected 00", {out_val, busy}); end
    checks++; if ({reg_en_v, val_op_v} !== 9'b0) begin errors++; $display("FAIL idle_en_op: got %b, expected 0", {reg_en_v, val_op_v}); end
  endtask

  task automatic test_single;
    bit ok;
    int ov0, oc0;
    lat = '{9, 9, 9, 9}; out_rdy = 1'b1;
    ov0 = outval_cycles; oc0 = out_cnt;
    offer(32'd3, 32'd5, 64'h000000000000000F, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept: got not accepted, expected accepted"); end
    @(negedge clk); in_val = 1'b0;
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain: timeout, expected idle"); end
    checks++; if (last_out_cyc - last_acc_cyc !== 41) begin errors++; $display("FAIL single_latency: got %0d, expected 41", last_out_cyc - last_acc_cyc); end
    checks++; if (outval_cycles - ov0 !== 1) begin errors++; $display("FAIL single_out_len: got %0d cycles, expected 1", outval_cycles - ov0); end
    checks++; if (out_cnt - oc0 !== 1) begin errors++; $display("FAIL single_count: got %0d, expected 1", out_cnt - oc0); end
`ifdef PIPE_MUL_PERF_EN
    checks++; if (perf_ops !== 32'd1) begin errors++; $display("FAIL single_perf_ops: got %0d, expected 1", perf_ops); end
`endif
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2, ok;
    int oc0;
    oc0 = out_cnt;
    offer(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 50, ok1);
    offer(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080, 50, ok2);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_accept: got %b%b, expected 11", ok1, ok2); end
    @(negedge clk); in_val = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: timeout, expected idle"); end
    checks++; if (out_cnt - oc0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d, expected 2", out_cnt - oc0); end
    checks++; if (last_out_cyc - prev_out_cyc !== 10) begin errors++; $display("FAIL b2b_gap: got %0d, expected 10", last_out_cyc - prev_out_cyc); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int a0, oc0, nok;
    logic [31:0] a, b;
    @(negedge clk); out_rdy = 1'b0;
    a0 = acc_cnt; oc0 = out_cnt; nok = 0;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom;
      offer(a, b, {32'd0, a} * {32'd0, b}, 400, ok);
      if (ok) nok++;
    end
    checks++; if (nok !== 5) begin errors++; $display("FAIL bp_first5: got %0d accepted, expected 5", nok); end
    offer(32'd11, 32'd13, 64'd143, 100, ok);
    if (!ok) in_val = 1'b0;
    else begin @(negedge clk); in_val = 1'b0; end
    #2;
    checks++; if (ok) begin errors++; $display("FAIL bp_sixth: got accepted, expected refused"); end
    checks++; if (acc_cnt - a0 !== 5) begin errors++; $display("FAIL bp_accepted: got %0d, expected 5", acc_cnt - a0); end
    checks++; if ({in_rdy, out_val, busy} !== 3'b011) begin errors++; $display("FAIL bp_state: got %b, expected 011", {in_rdy, out_val, busy}); end
`ifdef PIPE_MUL_PERF_EN
    checks++; if (perf_stall !== stall_cnt) begin errors++; $display("FAIL bp_perf_stall: got %0d, expected %0d", perf_stall, stall_cnt); end
`endif
    @(negedge clk); out_rdy = 1'b1;
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: timeout, expected idle"); end
    checks++; if (out_cnt - oc0 !== 5) begin errors++; $display("FAIL bp_count: got %0d, expected 5", out_cnt - oc0); end
  endtask

  task automatic test_late_c2;
    bit ok;
    int nok, oc0;
    int v0 [4];
    lat = '{9, 9, 30, 9}; out_rdy = 1'b1;
    v0 = vop_cnt; oc0 = out_cnt; nok = 0;
    for (int i = 0; i < 4; i++) begin
      offer(32'(i * 1000 + 17), 32'(i * 77 + 5), {32'd0, 32'(i * 1000 + 17)} * {32'd0, 32'(i * 77 + 5)}, 200, ok);
      if (ok) nok++;
    end
    @(negedge clk); in_val = 1'b0;
    checks++; if (nok !== 4) begin errors++; $display("FAIL late_accept: got %0d, expected 4", nok); end
    wait_idle(800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL late_drain: timeout, expected idle"); end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (vop_cnt[n] - v0[n] !== 4) begin errors++; $display("FAIL late_val_op_C%0d: got %0d pulses, expected 4", n, vop_cnt[n] - v0[n]); end
    end
    checks++; if (out_cnt - oc0 !== 4) begin errors++; $display("FAIL late_count: got %0d, expected 4", out_cnt - oc0); end
    checks++; if (last_out_cyc - prev_out_cyc !== 31) begin errors++; $display("FAIL late_gap: got %0d, expected 31", last_out_cyc - prev_out_cyc); end
    lat = '{9, 9, 9, 9};
  endtask

  task automatic test_reset_mid;
    bit ok;
    int nok, ov0, oc0, vt0, vt1;
    out_rdy = 1'b1; nok = 0;
    for (int i = 0; i < 3; i++) begin
      offer(32'(i + 2), 32'(i + 9), {32'd0, 32'(i + 2)} * {32'd0, 32'(i + 9)}, 100, ok);
      if (ok) nok++;
    end
    @(negedge clk); in_val = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (nok !== 3 || busy !== 1'b1) begin errors++; $display("FAIL mid_setup: got %0d accepted busy=%b, expected 3 busy=1", nok, busy); end
    @(negedge clk); reset = 1'b1; exp_q.delete();
    @(negedge clk); reset = 1'b0;
    #2;
    checks++; if ({busy, out_val} !== 2'b00) begin errors++; $display("FAIL mid_flush: got busy/out_val %b, expected 00", {busy, out_val}); end
    ov0 = outval_cycles; oc0 = out_cnt;
    vt0 = vop_cnt[0] + vop_cnt[1] + vop_cnt[2] + vop_cnt[3];
    repeat (12) @(negedge clk);
    #2;
    vt1 = vop_cnt[0] + vop_cnt[1] + vop_cnt[2] + vop_cnt[3];
    checks++; if (vt1 !== vt0 || outval_cycles !== ov0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_stale: got %0d val_op, %0d out_val cycles, busy=%b, expected 0 0 0", vt1 - vt0, outval_cycles - ov0, busy);
    end
    offer(32'd7, 32'd6, 64'h000000000000002A, 50, ok);
    @(negedge clk); in_val = 1'b0;
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_drain: timeout, expected idle"); end
    checks++; if (out_cnt - oc0 !== 1) begin errors++; $display("FAIL mid_count: got %0d, expected 1", out_cnt - oc0); end
`ifdef PIPE_MUL_PERF_EN
    checks++; if (perf_ops !== 32'd1) begin errors++; $display("FAIL mid_perf_ops: got %0d, expected 1", perf_ops); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_late_c2();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
